// File: rtl/axi4_reg_slave_pkg.sv
// axi_slave_pkg: response/burst encodings and FSM state types for the AXI4 register slave
package axi_slave_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/axi4_reg_slave_if.sv
// axi4_reg_slave_if: AXI4 write/read channel bundle between initiator and register slave
interface axi4_reg_slave_if #(
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int AXI_DATA_WIDTH   = 128,
   parameter int AXI_ID_WIDTH     = 16,
   parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3
);
   logic [AXI_ADDR_WIDTH-1:0]   awaddr;
   logic [AXI_ID_WIDTH-1:0]     awid;
   logic [7:0]                  awlen;
   logic [2:0]                  awsize;
   logic [1:0]                  awburst;
   logic [15:0]                 awuser;
   logic                        awvalid;
   logic                        awready;
   logic [AXI_DATA_WIDTH-1:0]   wdata;
   logic [AXI_STROBE_WIDTH-1:0] wstrb;
   logic                        wlast;
   logic                        wvalid;
   logic                        wready;
   logic [AXI_ID_WIDTH-1:0]     bid;
   logic [1:0]                  bresp;
   logic                        bvalid;
   logic                        bready;
   logic [AXI_ADDR_WIDTH-1:0]   araddr;
   logic [AXI_ID_WIDTH-1:0]     arid;
   logic [7:0]                  arlen;
   logic [2:0]                  arsize;
   logic [1:0]                  arburst;
   logic [15:0]                 aruser;
   logic                        arvalid;
   logic                        arready;
   logic [AXI_ID_WIDTH-1:0]     rid;
   logic [AXI_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                  rresp;
   logic                        rlast;
   logic                        rvalid;
   logic                        rready;
   modport master (
      output awaddr, awid, awlen, awsize, awburst, awuser, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output araddr, arid, arlen, arsize, arburst, aruser, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
   modport slave (
      input  awaddr, awid, awlen, awsize, awburst, awuser, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  araddr, arid, arlen, arsize, arburst, aruser, arvalid, rready,
      output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// axi4_burst_addr_gen: next beat address and register-range decode for one AXI channel
module axi4_burst_addr_gen import axi_slave_pkg::*; #(
   parameter int ADDR_W   = 32,
   parameter int STROBE_W = 16,
   parameter int NUM_REGS = 4
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr,
   output logic              in_range
);
   localparam int STROBE_LEN = $clog2(STROBE_W);
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS) << STROBE_LEN;
   // WRAP and reserved bursts advance like INCR; only FIXED holds the address
   assign next_addr = (burst == BURST_FIXED) ? addr : addr + ADDR_W'(STROBE_W);
   assign in_range  = addr < LIMIT;
endmodule

// File: rtl/axi4_reg_slave.sv
// axi4_reg_slave: AXI4 responder over a bank of bus-width control registers, exposed in parallel
module axi4_reg_slave import axi_slave_pkg::*; #(
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int AXI_DATA_WIDTH   = 128,
   parameter int AXI_ID_WIDTH     = 16,
   parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3,
   parameter int AXI_STROBE_LEN   = $clog2(AXI_STROBE_WIDTH),
   parameter int NUM_REGS         = 4
) (
   input  logic                               s_axi_aclk,
   input  logic                               s_axi_aresetn,
   axi4_reg_slave_if.slave                    s_axi,
   output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o
);
   localparam int IDX_W = $clog2(NUM_REGS);
   logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
   wr_state_t w_state, w_next;
   rd_state_t r_state, r_next;
   logic [AXI_ADDR_WIDTH-1:0] waddr, raddr, w_nxt_addr, r_cur_addr, r_nxt_addr;
   logic [AXI_ID_WIDTH-1:0] w_id, r_id;
   logic [7:0] wlen, wcnt, rlen, rcnt;
   logic [1:0] r_cur_burst, rburst, wburst;
   logic w_inr, r_inr, w_dec, w_slv, w_dec_now, w_slv_now;
   logic aw_hs, w_beat, w_last, ar_hs, r_hs;
   logic [IDX_W-1:0] widx, ridx;
   assign aw_hs       = s_axi.awvalid && s_axi.awready;
   assign w_beat      = s_axi.wvalid && s_axi.wready;
   assign w_last      = wcnt == wlen;
   assign ar_hs       = s_axi.arvalid && s_axi.arready;
   assign r_hs        = s_axi.rvalid && s_axi.rready;
   assign r_cur_addr  = (r_state == R_IDLE) ? s_axi.araddr : raddr;
   assign r_cur_burst = (r_state == R_IDLE) ? s_axi.arburst : rburst;
   assign widx        = waddr[AXI_STROBE_LEN +: IDX_W];
   assign ridx        = r_cur_addr[AXI_STROBE_LEN +: IDX_W];
   assign w_dec_now   = w_dec || !w_inr;
   assign w_slv_now   = w_slv || (s_axi.wlast != w_last);
   assign s_axi.bid   = w_id;
   assign s_axi.rid   = r_id;
   axi4_burst_addr_gen #(.ADDR_W(AXI_ADDR_WIDTH), .STROBE_W(AXI_STROBE_WIDTH), .NUM_REGS(NUM_REGS)) u_wgen (
      .addr(waddr), .burst(wburst), .next_addr(w_nxt_addr), .in_range(w_inr)
   );
   axi4_burst_addr_gen #(.ADDR_W(AXI_ADDR_WIDTH), .STROBE_W(AXI_STROBE_WIDTH), .NUM_REGS(NUM_REGS)) u_rgen (
      .addr(r_cur_addr), .burst(r_cur_burst), .next_addr(r_nxt_addr), .in_range(r_inr)
   );
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   always_comb begin
      w_next = (w_state == W_IDLE && aw_hs) ? W_DATA :
               (w_state == W_DATA && w_beat && w_last) ? W_RESP :
               (w_state == W_RESP && s_axi.bready) ? W_IDLE : w_state;
      r_next = (r_state == R_IDLE && ar_hs) ? R_DATA :
               (r_state == R_DATA && r_hs && s_axi.rlast) ? R_IDLE : r_state;
   end
   always_comb begin
      s_axi.wready = w_state == W_DATA;
      s_axi.bvalid = w_state == W_RESP;
      s_axi.rvalid = r_state == R_DATA;
   end
   // WRAP/reserved bursts seed the protocol-error flag at address time
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         s_axi.awready <= 1'b0;
         s_axi.bresp   <= RESP_OKAY;
         waddr         <= '0;
         w_id          <= '0;
         wlen          <= '0;
         wburst        <= '0;
         wcnt          <= '0;
         w_dec         <= 1'b0;
         w_slv         <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         s_axi.awready <= w_state == W_IDLE && s_axi.awvalid && !s_axi.awready;
         if (aw_hs) begin
            waddr  <= s_axi.awaddr;
            w_id   <= s_axi.awid;
            wlen   <= s_axi.awlen;
            wburst <= s_axi.awburst;
            wcnt   <= '0;
            w_dec  <= 1'b0;
            w_slv  <= s_axi.awburst[1];
         end
         if (w_beat) begin
            waddr <= w_nxt_addr;
            wcnt  <= wcnt + 8'd1;
            w_dec <= w_dec_now;
            w_slv <= w_slv_now;
            if (w_last) s_axi.bresp <= w_dec_now ? RESP_DECERR : w_slv_now ? RESP_SLVERR : RESP_OKAY;
            for (int b = 0; b < AXI_STROBE_WIDTH; b++)
               if (w_inr && s_axi.wstrb[b]) regs[widx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
         end
      end
   // beat 0 loads on the AR handshake; later beats load on each accepted non-last beat
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         s_axi.arready <= 1'b0;
         s_axi.rdata   <= '0;
         s_axi.rresp   <= RESP_OKAY;
         s_axi.rlast   <= 1'b0;
         raddr         <= '0;
         r_id          <= '0;
         rlen          <= '0;
         rburst        <= '0;
         rcnt          <= '0;
      end else begin
         s_axi.arready <= r_state == R_IDLE && s_axi.arvalid && !s_axi.arready;
         if (ar_hs) begin
            r_id   <= s_axi.arid;
            rlen   <= s_axi.arlen;
            rburst <= s_axi.arburst;
         end
         if (ar_hs || (r_hs && !s_axi.rlast)) begin
            raddr       <= r_nxt_addr;
            rcnt        <= ar_hs ? 8'd1 : rcnt + 8'd1;
            s_axi.rdata <= r_inr ? regs[ridx] : '0;
            s_axi.rresp <= !r_inr ? RESP_DECERR : r_cur_burst[1] ? RESP_SLVERR : RESP_OKAY;
            s_axi.rlast <= ar_hs ? (s_axi.arlen == 8'd0) : (rcnt == rlen);
         end else if (r_hs) s_axi.rlast <= 1'b0;
      end
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign regs_o[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[i];
   end
endmodule

// File: tb/tb_axi4_reg_slave.sv
// tb_axi4_reg_slave: scoreboard bench for the AXI4 register slave (B/R responses and regs_o)
module tb_axi4_reg_slave;
   import axi_slave_pkg::*;
   typedef struct packed {logic [15:0] id; logic [1:0] resp;} b_exp_t;
   typedef struct packed {logic [15:0] id; logic [127:0] data; logic [1:0] resp; logic last;} r_exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [511:0] regs_o;
   logic [127:0] mem [4];
   b_exp_t bq[$];
   r_exp_t rq[$];
   b_exp_t be;
   r_exp_t re;
   int vectors = 0;
   int miscompares = 0;
   always #5 clk = ~clk;
   axi4_reg_slave_if s_axi();
   axi4_reg_slave dut (.s_axi_aclk(clk), .s_axi_aresetn(rst_n), .s_axi(s_axi), .regs_o(regs_o));
   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   always @(negedge clk) if (rst_n) begin
      if (s_axi.bvalid && s_axi.bready) begin
         if (bq.size() == 0) check("b_unexpected", 1, 0);
         else begin
            be = bq.pop_front();
            check("bid", s_axi.bid, be.id);
            check("bresp", s_axi.bresp, be.resp);
         end
      end
      if (s_axi.rvalid && s_axi.rready) begin
         if (rq.size() == 0) check("r_unexpected", 1, 0);
         else begin
            re = rq.pop_front();
            check("rid", s_axi.rid, re.id);
            check("rdata", s_axi.rdata, re.data);
            check("rresp", s_axi.rresp, re.resp);
            check("rlast", s_axi.rlast, re.last);
         end
      end
   end
   task automatic bus_idle();
      s_axi.awaddr = '0; s_axi.awid = '0; s_axi.awlen = '0; s_axi.awsize = 3'd4; s_axi.awburst = '0;
      s_axi.awuser = '0; s_axi.awvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 0;
      s_axi.wvalid = 0; s_axi.bready = 1; s_axi.araddr = '0; s_axi.arid = '0; s_axi.arlen = '0;
      s_axi.arsize = 3'd4; s_axi.arburst = '0; s_axi.aruser = '0; s_axi.arvalid = 0; s_axi.rready = 1;
   endtask
   task automatic axi_write(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [127:0] base, input logic [15:0] strb,
                            input int last_at, input logic [1:0] resp);
      logic [31:0] a;
      int n;
      a = addr;
      bq.push_back(b_exp_t'({id, resp}));
      @(posedge clk); #1;
      s_axi.awaddr = addr; s_axi.awid = id; s_axi.awlen = len; s_axi.awburst = burst; s_axi.awvalid = 1;
      for (n = 0; n < 20 && !s_axi.awready; n++) @(negedge clk);
      check("awready_seen", s_axi.awready, 1);
      @(posedge clk); #1;
      s_axi.awvalid = 0;
      check("awready_pulse", s_axi.awready, 0);
      for (int k = 0; k <= len; k++) begin
         s_axi.wdata = base + 128'(k);
         s_axi.wstrb = strb;
         s_axi.wlast = (last_at < 0) ? (k == len) : (k == last_at);
         s_axi.wvalid = 1;
         for (n = 0; n < 20 && !s_axi.wready; n++) @(negedge clk);
         check("wready_seen", s_axi.wready, 1);
         if (a < 32'h40)
            for (int b = 0; b < 16; b++) if (strb[b]) mem[a[5:4]][b*8 +: 8] = s_axi.wdata[b*8 +: 8];
         a = (burst == BURST_FIXED) ? a : a + 32'd16;
         @(posedge clk); #1;
      end
      s_axi.wvalid = 0;
      s_axi.wlast = 0;
      for (n = 0; n < 20 && bq.size() != 0; n++) @(negedge clk);
      check("b_done", bq.size(), 0);
   endtask
   task automatic push_reads(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                             input logic [1:0] burst);
      logic [31:0] a;
      a = addr;
      for (int k = 0; k <= len; k++) begin
         rq.push_back(r_exp_t'({id, (a < 32'h40) ? mem[a[5:4]] : 128'h0,
                               (a >= 32'h40) ? RESP_DECERR : burst[1] ? RESP_SLVERR : RESP_OKAY, k == len}));
         a = (burst == BURST_FIXED) ? a : a + 32'd16;
      end
   endtask
   task automatic ar_cmd(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                         input logic [1:0] burst);
      int n;
      @(posedge clk); #1;
      s_axi.araddr = addr; s_axi.arid = id; s_axi.arlen = len; s_axi.arburst = burst; s_axi.arvalid = 1;
      for (n = 0; n < 20 && !s_axi.arready; n++) @(negedge clk);
      check("arready_seen", s_axi.arready, 1);
      @(posedge clk); #1;
      s_axi.arvalid = 0;
   endtask
   task automatic axi_read(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle);
      int n;
      push_reads(addr, id, len, burst);
      ar_cmd(addr, id, len, burst);
      for (n = 0; n < 100 && rq.size() != 0; n++) begin
         @(posedge clk); #1;
         if (toggle) s_axi.rready = ~s_axi.rready;
      end
      check("r_done", rq.size(), 0);
      s_axi.rready = 1;
   endtask
   task automatic reset_checks();
      check("rst_awready", s_axi.awready, 0);
      check("rst_wready", s_axi.wready, 0);
      check("rst_bvalid", s_axi.bvalid, 0);
      check("rst_arready", s_axi.arready, 0);
      check("rst_rvalid", s_axi.rvalid, 0);
      check("rst_rlast", s_axi.rlast, 0);
      check("rst_regs", regs_o[127:0] | regs_o[255:128] | regs_o[383:256] | regs_o[511:384], 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int n;
      bus_idle();
      for (int i = 0; i < 4; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1 reset_checks();
      @(negedge clk) rst_n = 1;
      axi_write(32'h10, 16'h00A5, 0, BURST_INCR, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, -1, RESP_OKAY);
      check("single_word1", regs_o[255:128], 128'h0123456789ABCDEF0123456789ABCDEF);
      axi_write(32'h20, 16'h0002, 0, BURST_INCR, {128{1'b1}}, 16'h0001, -1, RESP_OKAY);
      check("strb_word2", regs_o[383:256], 128'hFF);
      axi_read(32'h20, 16'h0003, 0, BURST_INCR, 0);
      axi_write(32'h00, 16'h0004, 3, BURST_INCR, 128'h1, 16'hFFFF, -1, RESP_OKAY);
      check("incr_word0", regs_o[127:0], 128'h1);
      check("incr_word1", regs_o[255:128], 128'h2);
      check("incr_word2", regs_o[383:256], 128'h3);
      check("incr_word3", regs_o[511:384], 128'h4);
      axi_read(32'h00, 16'h0005, 3, BURST_INCR, 1);
      axi_write(32'h30, 16'h0006, 1, BURST_INCR, 128'hAAAA, 16'hFFFF, -1, RESP_DECERR);
      check("oor_word3", regs_o[511:384], 128'hAAAA);
      check("oor_word0_kept", regs_o[127:0], 128'h1);
      axi_read(32'h40, 16'h0007, 0, BURST_INCR, 0);
      axi_write(32'h00, 16'h0008, 2, BURST_INCR, 128'h55, 16'hFFFF, 1, RESP_SLVERR);
      check("wlast_word2", regs_o[383:256], 128'h57);
      axi_read(32'h00, 16'h0009, 1, BURST_WRAP, 0);
      axi_write(32'h10, 16'h000A, 1, BURST_FIXED, 128'h10, 16'hFFFF, -1, RESP_OKAY);
      check("fixed_word1", regs_o[255:128], 128'h11);
      check("fixed_word2_kept", regs_o[383:256], 128'h57);
      axi_read(32'h10, 16'h000B, 1, BURST_FIXED, 0);
      push_reads(32'h00, 16'h0077, 3, BURST_INCR);
      ar_cmd(32'h00, 16'h0077, 3, BURST_INCR);
      for (n = 0; n < 20 && rq.size() > 2; n++) @(posedge clk);
      #2;
      check("pre_reset_rvalid", s_axi.rvalid, 1);
      rst_n = 0;
      rq.delete();
      for (int i = 0; i < 4; i++) mem[i] = '0;
      #1 reset_checks();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      repeat (3) @(negedge clk);
      check("post_reset_rvalid", s_axi.rvalid, 0);
      check("post_reset_bvalid", s_axi.bvalid, 0);
      axi_write(32'h10, 16'h00C3, 0, BURST_INCR, 128'hDEADBEEF, 16'hFFFF, -1, RESP_OKAY);
      check("post_reset_word1", regs_o[255:128], 128'hDEADBEEF);
      axi_read(32'h10, 16'h00C4, 0, BURST_INCR, 0);
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
